// File: rtl/branch_history_buffer.sv
// Local-history stage ahead of the pattern tables: tagged per-PC history lookup, in-flight queue, trained write-back.
// Optional BHB_BYPASS_EN forwards a same-cycle trained history to a hitting lookup.
module branch_history_buffer #(
    parameter int ENTRY_WIDTH = 4,
    parameter int HIST_WIDTH  = 3,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [9:0]            pc,
    output logic                  lookup_ready,
    output logic                  hit,
    output logic [HIST_WIDTH-1:0] prev_history,
    output logic                  evict,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    input  logic                  flush,
    output logic                  we,
    output logic [9:0]            old_pc,
    output logic [HIST_WIDTH-1:0] update_history,
    output logic                  branch_taken
);
    localparam int NUM_ENTRIES = 1 << ENTRY_WIDTH;
    localparam int TAG_WIDTH   = 10 - ENTRY_WIDTH;
    localparam int PTR_WIDTH   = $clog2(QUEUE_DEPTH);
    localparam int CNT_WIDTH   = $clog2(QUEUE_DEPTH) + 1;

    // History table
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_WIDTH-1:0]   tag_q  [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   tag_d  [NUM_ENTRIES];
    logic [HIST_WIDTH-1:0]  hist_q [NUM_ENTRIES];
    logic [HIST_WIDTH-1:0]  hist_d [NUM_ENTRIES];

    // In-flight queue
    logic [9:0]            qpc_q   [QUEUE_DEPTH];
    logic [9:0]            qpc_d   [QUEUE_DEPTH];
    logic [HIST_WIDTH-1:0] qhist_q [QUEUE_DEPTH];
    logic [HIST_WIDTH-1:0] qhist_d [QUEUE_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // Write-back registers
    logic                  we_q, we_d;
    logic [9:0]            old_pc_q, old_pc_d;
    logic [HIST_WIDTH-1:0] update_history_q, update_history_d;
    logic                  branch_taken_q, branch_taken_d;

    logic [ENTRY_WIDTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic                   lk_entry_valid;
    logic                   lk_match;
    logic                   full;
    logic                   empty;
    logic                   lookup_acc;
    logic                   resolve_acc;
    logic                   alloc_en;
    logic [9:0]             head_pc;
    logic [HIST_WIDTH-1:0]  head_hist;
    logic [ENTRY_WIDTH-1:0] head_idx;
    logic [TAG_WIDTH-1:0]   head_tag;
    logic                   train_en;
    logic [HIST_WIDTH-1:0]  trained_hist;
    logic [NUM_ENTRIES-1:0] alloc_sel;
    logic [NUM_ENTRIES-1:0] train_sel;

    assign lk_idx         = pc[ENTRY_WIDTH-1:0];
    assign lk_tag         = pc[9:ENTRY_WIDTH];
    assign lk_entry_valid = valid_q[lk_idx];
    assign lk_match       = (tag_q[lk_idx] == lk_tag);

    assign hit   = lookup_valid && lk_entry_valid && lk_match;
    assign evict = lookup_valid && lk_entry_valid && !lk_match;

    assign full         = (count_q == CNT_WIDTH'(QUEUE_DEPTH));
    assign empty        = (count_q == '0);
    assign lookup_ready = !full && !flush;
    assign lookup_acc   = lookup_valid && lookup_ready;
    assign resolve_acc  = resolve_valid && !empty && !flush;
    assign alloc_en     = lookup_acc && !hit;

    assign head_pc      = qpc_q[rd_ptr_q];
    assign head_hist    = qhist_q[rd_ptr_q];
    assign head_idx     = head_pc[ENTRY_WIDTH-1:0];
    assign head_tag     = head_pc[9:ENTRY_WIDTH];
    assign train_en     = resolve_acc && valid_q[head_idx] && (tag_q[head_idx] == head_tag);
    assign trained_hist = {hist_q[head_idx][HIST_WIDTH-2:0], resolve_taken};

    // A hit at the trained index implies the same tag, so the index compare suffices.
    always_comb begin
        prev_history = '0;
        if (hit) begin
            prev_history = hist_q[lk_idx];
        end
`ifdef BHB_BYPASS_EN
        if (hit && train_en && (head_idx == lk_idx)) begin
            prev_history = trained_hist;
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_sel
            assign alloc_sel[gi] = alloc_en && (lk_idx == ENTRY_WIDTH'(gi));
            assign train_sel[gi] = train_en && (head_idx == ENTRY_WIDTH'(gi));
        end
    endgenerate

    // Allocation takes priority over training when both target one entry.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            valid_d[i] = valid_q[i];
            tag_d[i]   = tag_q[i];
            hist_d[i]  = hist_q[i];
            if (alloc_sel[i]) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = lk_tag;
                hist_d[i]  = '0;
            end else if (train_sel[i]) begin
                hist_d[i] = trained_hist;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            qpc_d[i]   = qpc_q[i];
            qhist_d[i] = qhist_q[i];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (lookup_acc) begin
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    if (PTR_WIDTH'(i) == wr_ptr_q) begin
                        qpc_d[i]   = pc;
                        qhist_d[i] = prev_history;
                    end
                end
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (resolve_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({lookup_acc, resolve_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        we_d             = resolve_acc;
        old_pc_d         = old_pc_q;
        update_history_d = update_history_q;
        branch_taken_d   = branch_taken_q;
        if (resolve_acc) begin
            old_pc_d         = head_pc;
            update_history_d = head_hist;
            branch_taken_d   = resolve_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                hist_q[i] <= '0;
            end
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                qpc_q[i]   <= '0;
                qhist_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            we_q             <= 1'b0;
            old_pc_q         <= '0;
            update_history_q <= '0;
            branch_taken_q   <= 1'b0;
        end else begin
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            hist_q           <= hist_d;
            qpc_q            <= qpc_d;
            qhist_q          <= qhist_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            we_q             <= we_d;
            old_pc_q         <= old_pc_d;
            update_history_q <= update_history_d;
            branch_taken_q   <= branch_taken_d;
        end
    end

    assign we             = we_q;
    assign old_pc         = old_pc_q;
    assign update_history = update_history_q;
    assign branch_taken   = branch_taken_q;

endmodule

// File: doc/branch_history_buffer.md
# branch_history_buffer

Per-branch local-history stage that sits directly upstream of the pattern-prediction tables. On fetch it looks up a 16-entry tagged history table by PC and supplies the 3-bit local history and an eviction strobe for the predictor. It then holds each in-flight branch's PC and lookup-time history in a 4-deep queue. On resolution it trains the entry's history and drives the registered write-back (`we`, `old_pc`, `update_history`, `branch_taken`) into the predictor.

## Interface
- `ENTRY_WIDTH`, default 4: index bits; the table has `1<<ENTRY_WIDTH` entries and the index is `pc[ENTRY_WIDTH-1:0]`.
- `HIST_WIDTH`, default 3: local history bits.
- `QUEUE_DEPTH`, default 4: maximum number of in-flight branches; must be a power of two.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lookup_valid`  in  1  a fetched branch at `pc` requests a history.
- `pc`  in  10  fetch PC; tag is `pc[9:ENTRY_WIDTH]`.
- `lookup_ready`  out  1  the lookup is accepted this cycle.
- `hit`  out  1  the indexed entry is valid and its tag matches.
- `prev_history`  out  HIST_WIDTH  history for `pc`; 0 on miss.
- `evict`  out  1  `lookup_valid` and the indexed entry is valid with a mismatched tag.
- `resolve_valid`  in  1  the oldest in-flight branch has resolved.
- `resolve_taken`  in  1  outcome of that branch.
- `flush`  in  1  discard all in-flight branches.
- `we`  out  1  registered predictor write strobe.
- `old_pc`  out  10  registered PC of the trained branch.
- `update_history`  out  HIST_WIDTH  registered lookup-time history of the trained branch.
- `branch_taken`  out  1  registered outcome.

## Operation
- Table entry fields: `valid`, `tag[9-ENTRY_WIDTH:0]`, `hist[HIST_WIDTH-1:0]`.
- `hit`, `prev_history` and `evict` are combinational from `pc` and table state. They are gated by `lookup_valid`; all are 0 when it is low.
- `lookup_ready = !full && !flush`.
- Accepted lookup:
  - Pushes `{pc, prev_history}` into the queue.
  - On a miss (invalid entry or tag mismatch), the entry is allocated at the edge: `valid=1`, `tag=pc` tag, `hist=0`.
- Lookups when not ready cause no table change and no push; `evict` is still shown.
- Accepted resolve: `resolve_valid && !empty && !flush`.
  - Pops the queue head.
  - Next cycle: `we=1`, `old_pc`=head PC, `update_history`=head history, `branch_taken=resolve_taken`.
  - History training: if the entry at the head index is valid with a matching tag, `hist <= {hist[HIST_WIDTH-2:0], resolve_taken}`. Otherwise there is no table change, but `we` is still issued.
- A resolve on an empty queue is ignored; `we=0` next cycle.
- Flush clears the queue (count=0, pointers reset), retains the table and suppresses any same-cycle resolve (`we=0`).
- Same-cycle accepted lookup and resolve:
  - The count is unchanged when pushing and popping together.
  - Same index, lookup miss: the allocation wins and the training update is dropped.
  - Same index, lookup hit: training applies; `prev_history` shows the pre-update value unless bypass is configured.
- Queue occupancy is 0..QUEUE_DEPTH. Pointers wrap modulo QUEUE_DEPTH.
- `full` is count==QUEUE_DEPTH and `empty` is count==0; both derive from a `$clog2(QUEUE_DEPTH)+1`-bit count.

## Timing
- Lookup outputs have zero latency (combinational). Table and queue updates take effect at the next rising edge.
- Write-back outputs have 1-cycle latency from the accepted resolve. `we` is a single-cycle pulse per resolve.
- Reset (synchronous, at the edge with `rst=1`): all `valid=0`, all `hist=0`, queue empty, and `we=0`, `old_pc=0`, `update_history=0`, `branch_taken=0`.
- Reset while branches are in flight discards them with no write-back. Reset overrides flush, lookup and resolve.
- The combinational outputs after reset are `hit=0`, `prev_history=0`, `evict=0`, `lookup_ready=1`.

## Configuration
- `BHB_BYPASS_EN` defined: when an accepted resolve trains the entry at the same index and tag as a same-cycle lookup hit, `prev_history` shows the trained value `{hist[HIST_WIDTH-2:0], resolve_taken}`, and that value is pushed into the queue.
- `BHB_BYPASS_EN` undefined: `prev_history` always shows the registered `hist`.

## Test plan
- After reset, lookup pc=0x013 → `hit=0`, `prev_history=0`, `evict=0`, `lookup_ready=1`. Next cycle, lookup 0x013 → `hit=1`, `prev_history=0`.
- Lookup 0x013, then resolve taken three times (re-looking up 0x013 between resolves) → next-cycle `we=1`, `old_pc=0x013`, `update_history=0`, `branch_taken=1`; the entry's `hist` becomes 3'b111. Lookup 0x023 → `evict=1`, `hit=0`; the entry is reallocated with `hist=0`.
- Four lookups without resolve → `lookup_ready=0` on the fifth. Simultaneous resolve and lookup at full → `lookup_ready` stays 0 that cycle. One resolve alone → ready returns to 1 next cycle.
- Resolve on empty → `we=0`. Three in flight, then flush with `resolve_valid=1` → `we=0` next cycle; a subsequent resolve is ignored.
- Same-cycle hit lookup of 0x005 (`hist`=3'b001) and taken resolve of 0x005 → `prev_history`=3'b001 without `BHB_BYPASS_EN`, 3'b011 with it; `hist` becomes 3'b011.
- Reset asserted with two branches in flight → `we=0`, `old_pc=0` next cycle; the queue is empty and all lookups miss.
